// File: rtl/fp_align_shift_if.sv
// Handshake and data bundle for the FP adder alignment stage.
// The master side is the upstream swap stage plus the downstream consumer; the slave side is the
// aligner itself.
interface fp_align_shift_if #(
   parameter int unsigned MAN_W = 10,
   parameter int unsigned EXP_W = 5
) ();
   // input side
   logic             in_valid;
   logic             in_ready;
   logic [MAN_W-1:0] big_man;
   logic             big_sgn;
   logic [EXP_W-1:0] big_exp;
   logic [MAN_W-1:0] sml_man;
   logic             sml_sgn;
   logic [EXP_W-1:0] sml_exp;
   // output side
   logic             out_valid;
   logic             out_ready;
   logic [MAN_W-1:0] out_big_man;
   logic             out_big_sgn;
   logic             out_sml_sgn;
   logic [EXP_W-1:0] out_exp;
   logic [MAN_W-1:0] out_sml_man;
   logic             out_guard;
   logic             out_round;
   logic             out_sticky;
   logic             out_err;

   modport master (
      output in_valid, big_man, big_sgn, big_exp, sml_man, sml_sgn, sml_exp, out_ready,
      input  in_ready, out_valid, out_big_man, out_big_sgn, out_sml_sgn, out_exp,
             out_sml_man, out_guard, out_round, out_sticky, out_err
   );

   modport slave (
      input  in_valid, big_man, big_sgn, big_exp, sml_man, sml_sgn, sml_exp, out_ready,
      output in_ready, out_valid, out_big_man, out_big_sgn, out_sml_sgn, out_exp,
             out_sml_man, out_guard, out_round, out_sticky, out_err
   );
endinterface

// File: rtl/fp_align_shift.sv
// Alignment stage of the FP adder: right-shifts the small mantissa by the exponent difference,
// one bit per clock, producing guard/round/sticky for the later add/normalise/round stages.
module fp_align_shift #(
   parameter int unsigned MAN_W = 10,
   parameter int unsigned EXP_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   fp_align_shift_if.slave    bus
);
   localparam int unsigned SrW  = MAN_W + 2;
   localparam int unsigned CntW = $clog2(MAN_W + 3);

   // Shift amounts at or beyond SrW push every mantissa bit into sticky.
   localparam logic [EXP_W:0]  ClampE = (EXP_W + 1)'(SrW);
   localparam logic [CntW-1:0] ClampN = CntW'(SrW);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e           r_state;
   logic [SrW-1:0]   r_sr;
   logic             r_sticky;
   logic [CntW-1:0]  r_cnt;
   logic [MAN_W-1:0] r_big_man;
   logic             r_big_sgn;
   logic             r_sml_sgn;
   logic [EXP_W-1:0] r_exp;
   logic             r_err;

   logic [EXP_W:0]   w_diff;
   logic             w_borrow;
   logic [CntW-1:0]  w_n;
   logic             w_accept;

   // Exponent difference with borrow, clamped shift count.
   always_comb begin
      w_diff   = {1'b0, bus.big_exp} - {1'b0, bus.sml_exp};
      w_borrow = w_diff[EXP_W];
      w_n      = '0;
      if (!w_borrow) begin
         if (w_diff >= ClampE) w_n = ClampN;
         else                  w_n = CntW'(w_diff);
      end
      w_accept = bus.in_valid && (r_state == StIdle);
   end

   // Control FSM plus datapath registers; outputs come straight from these flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StIdle;
         r_sr      <= '0;
         r_sticky  <= 1'b0;
         r_cnt     <= '0;
         r_big_man <= '0;
         r_big_sgn <= 1'b0;
         r_sml_sgn <= 1'b0;
         r_exp     <= '0;
         r_err     <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_sr      <= {bus.sml_man, 2'b00};
                  r_sticky  <= 1'b0;
                  r_big_man <= bus.big_man;
                  r_big_sgn <= bus.big_sgn;
                  r_sml_sgn <= bus.sml_sgn;
                  r_exp     <= bus.big_exp;
                  r_err     <= w_borrow;
                  r_cnt     <= w_n;
                  r_state   <= (w_n == '0) ? StDone : StShift;
               end
            end
            StShift: begin
               r_sr     <= {1'b0, r_sr[SrW-1:1]};
               r_sticky <= r_sticky | r_sr[0];
               r_cnt    <= r_cnt - CntW'(1);
               if (r_cnt == CntW'(1)) r_state <= StDone;
            end
            StDone: begin
               if (bus.out_ready) r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign bus.in_ready    = (r_state == StIdle);
   assign bus.out_valid   = (r_state == StDone);
   assign bus.out_big_man = r_big_man;
   assign bus.out_big_sgn = r_big_sgn;
   assign bus.out_sml_sgn = r_sml_sgn;
   assign bus.out_exp     = r_exp;
   assign bus.out_sml_man = r_sr[SrW-1:2];
   assign bus.out_guard   = r_sr[1];
   assign bus.out_round   = r_sr[0];
   assign bus.out_sticky  = r_sticky;
   assign bus.out_err     = r_err;
endmodule

// File: tb/tb_fp_align_shift.sv
// Directed bench for fp_align_shift: expected results are modelled and queued at stimulus time,
// then popped and compared when out_valid appears.
module tb_fp_align_shift;
   localparam int unsigned MAN_W = 10;
   localparam int unsigned EXP_W = 5;
   localparam int          MaxWait = 40;

   logic clk;
   logic rst_n;

   fp_align_shift_if #(.MAN_W(MAN_W), .EXP_W(EXP_W)) bus ();

   fp_align_shift #(.MAN_W(MAN_W), .EXP_W(EXP_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [MAN_W-1:0] man;
      logic             g;
      logic             r;
      logic             s;
      logic [EXP_W-1:0] exp;
      logic             err;
      logic [MAN_W-1:0] big_man;
      logic             big_sgn;
      logic             sml_sgn;
      logic [7:0]       lat;
   } exp_t;

   exp_t q_exp[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Reference: whole-word shift of {man,00} by min(diff,12); sticky = any bit shifted out past R.
   function automatic exp_t model(input logic [MAN_W-1:0] bm, input logic bs,
                                  input logic [EXP_W-1:0] be, input logic [MAN_W-1:0] sm,
                                  input logic ss, input logic [EXP_W-1:0] se);
      exp_t e;
      int d;
      int n;
      logic [MAN_W+1:0] v;
      logic [MAN_W+1:0] a;
      logic [MAN_W+1:0] mask;
      d = int'(be) - int'(se);
      n = (d < 0) ? 0 : ((d > MAN_W + 2) ? MAN_W + 2 : d);
      v = {sm, 2'b00};
      a = v >> n;
      mask = ((MAN_W + 2)'(1) << n) - (MAN_W + 2)'(1);
      e.man     = a[MAN_W+1:2];
      e.g       = a[1];
      e.r       = a[0];
      e.s       = |(v & mask);
      e.exp     = be;
      e.err     = (d < 0);
      e.big_man = bm;
      e.big_sgn = bs;
      e.sml_sgn = ss;
      e.lat     = 8'(n + 1);
      return e;
   endfunction

   // Present a pair and hold in_valid until it is accepted; returns #1 after the accepting edge.
   task automatic drive_accept(input logic [MAN_W-1:0] bm, input logic bs,
                               input logic [EXP_W-1:0] be, input logic [MAN_W-1:0] sm,
                               input logic ss, input logic [EXP_W-1:0] se);
      int w;
      bus.big_man = bm; bus.big_sgn = bs; bus.big_exp = be;
      bus.sml_man = sm; bus.sml_sgn = ss; bus.sml_exp = se;
      bus.in_valid = 1'b1;
      w = 0;
      while (!bus.in_ready && w < MaxWait) begin
         @(posedge clk); #1; w++;
      end
      if (!bus.in_ready) check("accept_timeout", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic send(input logic [MAN_W-1:0] bm, input logic bs, input logic [EXP_W-1:0] be,
                       input logic [MAN_W-1:0] sm, input logic ss, input logic [EXP_W-1:0] se);
      q_exp.push_back(model(bm, bs, be, sm, ss, se));
      drive_accept(bm, bs, be, sm, ss, se);
   endtask

   // Wait for out_valid (latency counted from the accepting edge), pop and compare.
   task automatic wait_result(input string tag);
      int   lat;
      exp_t e;
      lat = 1;
      while (!bus.out_valid && lat < MaxWait) begin
         @(posedge clk); #1; lat++;
      end
      e = q_exp.pop_front();
      if (!bus.out_valid) begin
         check({tag, "_timeout"}, 32'(bus.out_valid), 32'd1);
         return;
      end
      bus.in_valid = 1'b0;
      check({tag, "_lat"},     32'(lat),             32'(e.lat));
      check({tag, "_man"},     32'(bus.out_sml_man), 32'(e.man));
      check({tag, "_grs"},     32'({bus.out_guard, bus.out_round, bus.out_sticky}),
                               32'({e.g, e.r, e.s}));
      check({tag, "_exp"},     32'(bus.out_exp),     32'(e.exp));
      check({tag, "_err"},     32'(bus.out_err),     32'(e.err));
      check({tag, "_bigman"},  32'(bus.out_big_man), 32'(e.big_man));
      check({tag, "_sgns"},    32'({bus.out_big_sgn, bus.out_sml_sgn}),
                               32'({e.big_sgn, e.sml_sgn}));
      check({tag, "_inrdy_lo"}, 32'(bus.in_ready),   32'd0);
      if (bus.out_ready) begin
         @(posedge clk); #1;
         check({tag, "_inrdy_hi"}, 32'(bus.in_ready), 32'd1);
         check({tag, "_vld_lo"},   32'(bus.out_valid), 32'd0);
      end
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      bus.big_man = '0; bus.big_sgn = 1'b0; bus.big_exp = '0;
      bus.sml_man = '0; bus.sml_sgn = 1'b0; bus.sml_exp = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_inrdy",  32'(bus.in_ready),  32'd1);
      check("rst_vld",    32'(bus.out_valid), 32'd0);
      check("rst_man",    32'(bus.out_sml_man), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // diff 6, with in_valid junk driven while shifting (must be ignored)
      send(10'd0, 1'b0, 5'd17, 10'd32, 1'b1, 5'd11);
      bus.big_man = 10'd999; bus.big_exp = 5'd3; bus.sml_man = 10'd5; bus.sml_exp = 5'd1;
      bus.in_valid = 1'b1;
      wait_result("d6");

      // diff 0
      send(10'd14, 1'b1, 5'd11, 10'd3, 1'b0, 5'd11);
      wait_result("d0");

      // diff 2 and diff 3
      send(10'd897, 1'b0, 5'd29, 10'd141, 1'b0, 5'd27);
      wait_result("d2");
      send(10'd5, 1'b1, 5'd14, 10'd1, 1'b1, 5'd11);
      wait_result("d3");

      // clamp: diff 31 behaves as 12
      send(10'd0, 1'b0, 5'd31, 10'd1023, 1'b0, 5'd0);
      wait_result("clamp");

      // diff exactly 12 and 11 around the clamp boundary
      send(10'd1, 1'b0, 5'd12, 10'd512, 1'b0, 5'd0);
      wait_result("d12");
      send(10'd1, 1'b0, 5'd11, 10'd513, 1'b0, 5'd0);
      wait_result("d11");

      // ordering violation
      send(10'd484, 1'b0, 5'd9, 10'd391, 1'b1, 5'd11);
      wait_result("err");

      // hold out_ready low in DONE for 5 cycles
      bus.out_ready = 1'b0;
      send(10'd77, 1'b1, 5'd20, 10'd600, 1'b0, 5'd16);
      wait_result("hold");
      bus.in_valid = 1'b1;
      bus.big_exp = 5'd1; bus.sml_exp = 5'd1; bus.big_man = 10'd3; bus.sml_man = 10'd3;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("hold_vld",   32'(bus.out_valid),   32'd1);
         check("hold_inrdy", 32'(bus.in_ready),    32'd0);
         check("hold_man",   32'(bus.out_sml_man), 32'd37);
         check("hold_grs",   32'({bus.out_guard, bus.out_round, bus.out_sticky}), 32'b100);
         check("hold_exp",   32'(bus.out_exp),     32'd20);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("hold_rel_inrdy", 32'(bus.in_ready),  32'd1);
      check("hold_rel_vld",   32'(bus.out_valid), 32'd0);

      // asynchronous reset mid-SHIFT
      drive_accept(10'd700, 1'b1, 5'd31, 10'd1023, 1'b1, 5'd0);
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_vld",    32'(bus.out_valid),   32'd0);
      check("arst_inrdy",  32'(bus.in_ready),    32'd1);
      check("arst_man",    32'(bus.out_sml_man), 32'd0);
      check("arst_bigman", 32'(bus.out_big_man), 32'd0);
      check("arst_exp",    32'(bus.out_exp),     32'd0);
      check("arst_misc",   32'({bus.out_guard, bus.out_round, bus.out_sticky, bus.out_err,
                                bus.out_big_sgn, bus.out_sml_sgn}), 32'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send(10'd9, 1'b0, 5'd4, 10'd6, 1'b1, 5'd4);
      wait_result("post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
